// File: rtl/blocking_cache_alt_ctrl_pkg.sv
// Shared definitions for the 2-way blocking cache controller.
//  - FSM state encoding
//  - cache message type codes (READ/WRITE/INIT)
//  - address/line/data widths and write-byte-enable helpers
package blocking_cache_alt_ctrl_pkg;

  localparam int abw = 32;                 // address bits
  localparam int clw = 128;                // cache line bits
  localparam int dbw = 32;                 // data word bits
  localparam int ofw = $clog2(clw / 8);    // byte offset bits within a line

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE, // wait for request
    S_TC,   // tag check
    S_IN,   // init write
    S_RD,   // data read
    S_WD,   // data write
    S_EP,   // eviction prepare (read victim line + tag)
    S_ER,   // eviction memory request
    S_EW,   // eviction memory wait
    S_RR,   // refill memory request
    S_RW,   // refill memory wait
    S_RU,   // refill update
    S_W     // response
  } state_e;

  // Any code other than WRITE/INIT behaves as a READ.
  function automatic logic [2:0] norm_type(input logic [2:0] t);
    return (t == TYPE_WRITE || t == TYPE_INIT) ? t : TYPE_READ;
  endfunction

  // Byte enables for one 4B word of a 16B line.
  function automatic logic [15:0] word_wben(input logic [1:0] word_off);
    logic [15:0] base;
    base = 16'h000F;
    return base << {word_off, 2'b00};
  endfunction

endpackage

// File: rtl/blocking_cache_alt_ctrl_state_bits.sv
// Per-set valid/dirty/LRU storage for a 2-way cache.
// Ports:
//  clk, reset       clock, asynchronous active-low clear of all bits
//  idx_i            set index (shared by read and write ports)
//  valid_o/dirty_o  per-way bits of set idx_i; lru_o = least-recent way
//  way_i            way targeted by the set/clear/lru write ports
//  set_valid_i, set_dirty_i, clr_dirty_i  bit write ports
//  lru_we_i         record way_i as most recent (LRU <= ~way_i)
module blocking_cache_alt_ctrl_state_bits #(
  parameter int p_nby = 8,
  localparam int idw  = $clog2(p_nby)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [idw-1:0] idx_i,
  output logic [1:0]     valid_o,
  output logic [1:0]     dirty_o,
  output logic           lru_o,
  input  logic           way_i,
  input  logic           set_valid_i,
  input  logic           set_dirty_i,
  input  logic           clr_dirty_i,
  input  logic           lru_we_i
);

  logic [p_nby-1:0][1:0] valid_q;
  logic [p_nby-1:0][1:0] dirty_q;
  logic [p_nby-1:0]      lru_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (set_valid_i) valid_q[idx_i][way_i] <= 1'b1;
      if (set_dirty_i)      dirty_q[idx_i][way_i] <= 1'b1;
      else if (clr_dirty_i) dirty_q[idx_i][way_i] <= 1'b0;
      if (lru_we_i) lru_q[idx_i] <= ~way_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign lru_o   = lru_q[idx_i];

endmodule

// File: rtl/blocking_cache_alt_ctrl.sv
// FSM controller for a 2-way set-associative, write-back, write-allocate
// blocking cache datapath. One request at a time: tag check, data access,
// optional dirty eviction and 16B refill, then a single response.
// Ports:
//  clk, reset                 clock, asynchronous active-low reset
//  cachereq_*/cacheresp_*     processor val/rdy handshakes
//  memreq_*/memresp_*         memory val/rdy handshakes
//  *_en, *_mux_sel            datapath register enables / mux selects
//  tag_array_*, data_array_*  SRAM control (data_array_wben = byte enables)
//  hit                        registered tag-check result
//  cacheresp_type/memreq_type message types
//  cachereq_type/addr, tag_match0/1  datapath status (latched request)
// Optional feature (macro BLOCKING_CACHE_CTRL_HIT_CNT_EN): adds 32-bit
// hit_count/miss_count outputs, each bumped once per tag check.
module blocking_cache_alt_ctrl
  import blocking_cache_alt_ctrl_pkg::*;
#(
  parameter int p_idx_shamt = 0,
  parameter int p_nby       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cachereq_val,
  output logic        cachereq_rdy,
  output logic        cacheresp_val,
  input  logic        cacheresp_rdy,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  output logic        cachereq_en,
  output logic        memresp_en,
  output logic        evict_addr_reg_en,
  output logic        read_data_reg_en,
  output logic        cacheresp_data_mux_sel,
  output logic        write_data_mux_sel,
  output logic        memreq_addr_mux_sel,
  output logic        cache_way_mux_sel,
  output logic        tag_array_ren,
  output logic        tag_array0_wen,
  output logic        tag_array1_wen,
  output logic        data_array_ren,
  output logic        data_array0_wen,
  output logic        data_array1_wen,
  output logic [15:0] data_array_wben,
  output logic        hit,
  output logic [2:0]  cacheresp_type,
  output logic [2:0]  memreq_type,
  input  logic [2:0]  cachereq_type,
  input  logic [31:0] cachereq_addr,
  input  logic        tag_match0,
  input  logic        tag_match1
`ifdef BLOCKING_CACHE_CTRL_HIT_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int idw = $clog2(p_nby);

  state_e state_q, state_d;
  logic   way_q, way_d;
  logic   hit_q, hit_d;

  logic [idw-1:0] idx;
  logic [1:0]     valid, dirty;
  logic           lru;
  logic           set_valid, set_dirty, clr_dirty, lru_we;
  logic           tag_we, data_we;
  logic [2:0]     req_type;
  logic           unused_addr;

  assign idx         = cachereq_addr[idw+p_idx_shamt+ofw-1 -: idw];
  assign req_type    = norm_type(cachereq_type);
  assign unused_addr = ^cachereq_addr;

  blocking_cache_alt_ctrl_state_bits #(.p_nby(p_nby)) u_bits (
    .clk         (clk),
    .reset       (reset),
    .idx_i       (idx),
    .valid_o     (valid),
    .dirty_o     (dirty),
    .lru_o       (lru),
    .way_i       (way_q),
    .set_valid_i (set_valid),
    .set_dirty_i (set_dirty),
    .clr_dirty_i (clr_dirty),
    .lru_we_i    (lru_we)
  );

  // Tag check. The victim fills the lowest invalid way first; once both
  // ways are valid it is the least-recently used way held in the LRU bit.
  logic hit0, hit1, tc_hit, victim, tc_way, victim_dirty;
  assign hit0         = valid[0] & tag_match0;
  assign hit1         = valid[1] & tag_match1;
  assign tc_hit       = hit0 | hit1;
  assign victim       = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);
  assign tc_way       = tc_hit ? ~hit0 : victim;
  assign victim_dirty = valid[victim] & dirty[victim];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      way_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    way_d                  = way_q;
    hit_d                  = hit_q;
    cachereq_rdy           = 1'b0;
    cacheresp_val          = 1'b0;
    memreq_val             = 1'b0;
    memresp_rdy            = 1'b0;
    cachereq_en            = 1'b0;
    memresp_en             = 1'b0;
    evict_addr_reg_en      = 1'b0;
    read_data_reg_en       = 1'b0;
    cacheresp_data_mux_sel = 1'b0;
    write_data_mux_sel     = 1'b0;
    memreq_addr_mux_sel    = 1'b0;
    cache_way_mux_sel      = way_q;
    tag_array_ren          = 1'b0;
    data_array_ren         = 1'b0;
    data_array_wben        = 16'h0000;
    cacheresp_type         = 3'd0;
    memreq_type            = 3'd0;
    tag_we                 = 1'b0;
    data_we                = 1'b0;
    set_valid              = 1'b0;
    set_dirty              = 1'b0;
    clr_dirty              = 1'b0;
    lru_we                 = 1'b0;
    // While reset is held the only state-dependent outputs (IDLE) stay low.
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          cachereq_rdy = 1'b1;
          cachereq_en  = cachereq_val;
          if (cachereq_val) state_d = S_TC;
        end
        S_TC: begin
          tag_array_ren     = 1'b1;
          cache_way_mux_sel = tc_way;
          way_d             = tc_way;
          hit_d             = tc_hit;
          if (req_type == TYPE_INIT) state_d = S_IN;
          else if (tc_hit)           state_d = (req_type == TYPE_WRITE) ? S_WD : S_RD;
          else if (victim_dirty)     state_d = S_EP;
          else                       state_d = S_RR;
        end
        S_IN: begin
          tag_we          = 1'b1;
          data_we         = 1'b1;
          data_array_wben = word_wben(cachereq_addr[3:2]);
          set_valid       = 1'b1;
          set_dirty       = 1'b1;
          lru_we          = 1'b1;
          state_d         = S_W;
        end
        S_RD: begin
          data_array_ren   = 1'b1;
          read_data_reg_en = 1'b1;
          lru_we           = 1'b1;
          state_d          = S_W;
        end
        S_WD: begin
          data_we         = 1'b1;
          data_array_wben = word_wben(cachereq_addr[3:2]);
          set_dirty       = 1'b1;
          lru_we          = 1'b1;
          state_d         = S_W;
        end
        S_EP: begin
          tag_array_ren     = 1'b1;
          data_array_ren    = 1'b1;
          read_data_reg_en  = 1'b1;
          evict_addr_reg_en = 1'b1;
          state_d           = S_ER;
        end
        S_ER: begin
          memreq_val          = 1'b1;
          memreq_type         = TYPE_WRITE;
          memreq_addr_mux_sel = 1'b0;
          if (memreq_rdy) state_d = S_EW;
        end
        S_EW: begin
          memresp_rdy = 1'b1;
          if (memresp_val) state_d = S_RR;
        end
        S_RR: begin
          memreq_val          = 1'b1;
          memreq_type         = TYPE_READ;
          memreq_addr_mux_sel = 1'b1;
          if (memreq_rdy) state_d = S_RW;
        end
        S_RW: begin
          memresp_rdy = 1'b1;
          memresp_en  = memresp_val;
          if (memresp_val) state_d = S_RU;
        end
        S_RU: begin
          tag_we             = 1'b1;
          data_we            = 1'b1;
          data_array_wben    = 16'hFFFF;
          write_data_mux_sel = 1'b1;
          set_valid          = 1'b1;
          clr_dirty          = 1'b1;
          state_d            = (req_type == TYPE_WRITE) ? S_WD : S_RD;
        end
        S_W: begin
          cacheresp_val          = 1'b1;
          cacheresp_type         = req_type;
          cacheresp_data_mux_sel = (req_type == TYPE_READ);
          if (cacheresp_rdy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tag_array0_wen  = tag_we  & ~way_q;
  assign tag_array1_wen  = tag_we  &  way_q;
  assign data_array0_wen = data_we & ~way_q;
  assign data_array1_wen = data_we &  way_q;
  assign hit             = hit_q;

`ifdef BLOCKING_CACHE_CTRL_HIT_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // TC always lasts exactly one cycle, so this counts each lookup once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_TC) begin
      if (tc_hit || req_type == TYPE_INIT) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else                                 miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
